// File: rtl/mexiko_g18_pkg.sv
// Shared types and constants for the G18 BPI flash bridge.
// Holds the fetch FSM state encoding plus the flash address and data widths.
package mexiko_g18_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    ACK
  } g18_state_t;

  localparam int G18_ADDR_BITS = 23;
  localparam int G18_DATA_BITS = 16;

endpackage

// File: rtl/g18_wb_flash_bridge.sv
// Read-only Wishbone B3 classic slave that fetches 32-bit words from the
// 16-bit G18 BPI flash. Each word takes two halfword reads, high half first.
// A one-word buffer (data + tag + valid) answers a repeated read in one cycle.
//
// Ports
//   sys_clk_i, sys_rst_ni       clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i   Wishbone request (only adr[ADDR_BITS:2] and we are used)
//   wb_cyc_i, wb_stb_i          Wishbone cycle / strobe
//   wb_dat_o, wb_ack_o          read data and one-cycle read acknowledge
//   wb_err_o                    one-cycle error pulse for any write
//   cache_inv_i                 clears the word buffer
//   g18_adr_o, g18_dat_i        flash halfword address / read data
//   g18_wen_o                   flash write enable (active low, held high)
import mexiko_g18_pkg::*;

module g18_wb_flash_bridge #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BITS   = G18_ADDR_BITS
) (
  input  logic                     sys_clk_i,
  input  logic                     sys_rst_ni,
  input  logic [31:0]              wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  input  logic                     cache_inv_i,
  output logic [ADDR_BITS-1:0]     g18_adr_o,
  input  logic [G18_DATA_BITS-1:0] g18_dat_i,
  output logic                     g18_wen_o
);

  localparam int WORD_BITS = ADDR_BITS - 1;
  localparam int CNT_W     = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  g18_state_t                 state_q, state_d;
  logic [CNT_W-1:0]           cnt_q;
  logic [WORD_BITS-1:0]       word_q;
  logic [G18_DATA_BITS-1:0]   hi_q;
  logic [31:0]                buf_q;
  logic [WORD_BITS-1:0]       tag_q;
  logic                       valid_q;
  logic                       ack_q;    // hit acknowledge
  logic                       err_q;
  logic                       abort_q;  // master dropped cyc during the fetch
  logic [31:0]                dat_q;
  logic [ADDR_BITS-1:0]       adr_q;

  logic [WORD_BITS-1:0]       word;
  logic                       req;
  logic                       hit;
  logic                       cnt_zero;
  logic                       abort_now;

  // Byte lanes, write data and out-of-window address bits do not affect a read.
  logic unused_inputs;
  assign unused_inputs = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADDR_BITS+1], wb_adr_i[1:0]};

  assign word      = wb_adr_i[ADDR_BITS:2];
  assign cnt_zero  = (cnt_q == '0);
  assign abort_now = abort_q || !wb_cyc_i;
  // A pending ack/err pulse blocks acceptance so a request is never answered twice.
  assign req       = (state_q == IDLE) && wb_cyc_i && wb_stb_i && !ack_q && !err_q;
  // An invalidate arriving with the request forces a refetch.
  assign hit       = valid_q && (tag_q == word) && !cache_inv_i;

  // NOTE: every output of an always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wb_ack_o = ack_q || (state_q == ACK);
    unique case (state_q)
      IDLE: if (req && !wb_we_i && !hit) state_d = HI;
      HI:   if (cnt_zero) state_d = LO;
      LO:   if (cnt_zero) state_d = abort_now ? IDLE : ACK;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the word buffer is a single register, so it is reset along with the
  // rest of the state; a true RAM array would be left unreset.
  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      hi_q    <= '0;
      buf_q   <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      dat_q   <= '0;
      adr_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before this edge, regardless of statement order.
      state_q <= state_d;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      if (cache_inv_i) valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (wb_we_i) begin
              err_q <= 1'b1;
            end else if (hit) begin
              ack_q <= 1'b1;
              dat_q <= buf_q;
            end else begin
              word_q  <= word;
              adr_q   <= {word, 1'b0};
              cnt_q   <= CNT_W'(WAIT_CYCLES);
              abort_q <= 1'b0;
            end
          end
        end
        HI: begin
          abort_q <= abort_now;
          if (cnt_zero) begin
            hi_q  <= g18_dat_i;
            adr_q <= {word_q, 1'b1};
            cnt_q <= CNT_W'(WAIT_CYCLES);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        LO: begin
          abort_q <= abort_now;
          if (cnt_zero) begin
            buf_q   <= {hi_q, g18_dat_i};
            tag_q   <= word_q;
            // Invalidate in the final cycle wins; the fetched word still goes out.
            valid_q <= !cache_inv_i;
            dat_q   <= {hi_q, g18_dat_i};
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_err_o  = err_q;
  assign g18_adr_o = adr_q;
  assign g18_wen_o = 1'b1;

endmodule
